// File: rtl/vj_stage_eval.sv
// Cascade stage evaluator: sums signed feature contributions per stage and
// early-exits on the first stage whose sum falls below its threshold.
module vj_stage_eval #(
    parameter int NUM_STAGES   = 25,
    parameter int MAX_FEATURES = 256,
    parameter int STAGE_W      = $clog2(NUM_STAGES),
    parameter int FEAT_W       = $clog2(MAX_FEATURES + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                win_valid,
    output logic                win_ready,
    input  logic                win_abort,
    input  logic                feat_valid,
    output logic                feat_ready,
    input  logic signed [31:0]  feat_accum,
    output logic [STAGE_W-1:0]  stage_idx,
    output logic [FEAT_W-1:0]   feat_idx,
    input  logic [FEAT_W-1:0]   stage_len,
    input  logic signed [31:0]  stage_thresh,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                result_face,
    output logic [STAGE_W-1:0]  result_stage
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_RESULT
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_t               state, state_nxt;
    logic [STAGE_W-1:0]   stage_nxt;
    logic [FEAT_W-1:0]    feat_nxt;
    logic signed [31:0]   sum, sum_nxt, sum_add;
    logic                 face_nxt;
    logic [STAGE_W-1:0]   rstage_nxt;
    logic                 eval, pass, last_feat, last_stage, empty_stage;

    assign win_ready    = (state == S_IDLE);
    assign result_valid = (state == S_RESULT);
    assign empty_stage  = (stage_len == '0);
    assign feat_ready   = (state == S_ACCUM) && !empty_stage;

    // Wraps modulo 2^32 by construction; no saturation.
    assign sum_add    = sum + feat_accum;
    assign last_feat  = (feat_idx == stage_len - FEAT_W'(1));
    assign last_stage = (stage_idx == LAST_STAGE);

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can leave a value unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        stage_nxt  = stage_idx;
        feat_nxt   = feat_idx;
        sum_nxt    = sum;
        face_nxt   = result_face;
        rstage_nxt = result_stage;
        eval       = 1'b0;
        pass       = 1'b0;

        case (state)
            S_IDLE: begin
                if (win_valid && !win_abort) begin
                    state_nxt = S_ACCUM;
                    stage_nxt = '0;
                    feat_nxt  = '0;
                    sum_nxt   = '0;
                end
            end

            S_ACCUM: begin
                if (win_abort) begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                    feat_nxt  = '0;
                    sum_nxt   = '0;
                end else if (empty_stage) begin
                    // An empty stage is decided on a zero sum without a feature.
                    eval = 1'b1;
                    pass = (stage_thresh <= 32'sd0);
                end else if (feat_valid) begin
                    if (!last_feat) begin
                        feat_nxt = feat_idx + FEAT_W'(1);
                        sum_nxt  = sum_add;
                    end else begin
                        eval = 1'b1;
                        pass = (sum_add >= stage_thresh);
                    end
                end

                if (eval) begin
                    if (pass && !last_stage) begin
                        stage_nxt = stage_idx + STAGE_W'(1);
                        feat_nxt  = '0;
                        sum_nxt   = '0;
                    end else begin
                        state_nxt  = S_RESULT;
                        face_nxt   = pass;
                        rstage_nxt = stage_idx;
                    end
                end
            end

            S_RESULT: begin
                if (win_abort || result_ready) begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                    feat_nxt  = '0;
                    sum_nxt   = '0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            stage_idx    <= '0;
            feat_idx     <= '0;
            sum          <= '0;
            result_face  <= 1'b0;
            result_stage <= '0;
        end else begin
            state        <= state_nxt;
            stage_idx    <= stage_nxt;
            feat_idx     <= feat_nxt;
            sum          <= sum_nxt;
            result_face  <= face_nxt;
            result_stage <= rstage_nxt;
        end
    end

endmodule
